// File: rtl/sift_pkg.sv
// rtl/sift_pkg.sv - shared widths and types for the scale-space window path
package sift_pkg;
    localparam int KERNEL_SIZE        = 3;
    localparam int DEFAULT_DIFF_WIDTH = 14;
    localparam int LB_ROWS            = KERNEL_SIZE - 1;

    typedef logic signed [DEFAULT_DIFF_WIDTH-1:0] diff_t;
    typedef diff_t [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0] kernel_t;
endpackage

// File: rtl/extreme_line_buffer.sv
// rtl/extreme_line_buffer.sv - per-layer two-row line store, 1W1R sync RAM
// Each word holds one sample per lane; a single lane is written per row so the
// read (old data) always returns the two previous rows at this column.
module extreme_line_buffer
    import sift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_DIFF_WIDTH,
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [LB_ROWS-1:0]       wr_lane,
    input  logic [AW-1:0]            addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [LB_ROWS*WIDTH-1:0] rdata
);
    logic [LB_ROWS*WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            for (int i = 0; i < LB_ROWS; i++) begin
                if (wr_lane[i]) begin
                    mem[addr][i*WIDTH +: WIDTH] <= wdata;
                end
            end
        end
    end
endmodule

// File: rtl/extreme_window_gen.sv
// rtl/extreme_window_gen.sv - 3x3x3 DoG neighbourhood builder for extreme_find
// Stage 1: accept, counters, line-buffer read. Stage 2: column shift and window/coord output.
module extreme_window_gen
    import sift_pkg::*;
#(
    parameter int IMAGE_COLUMN        = 512,
    parameter int IMAGE_ROW           = 512,
    parameter int EXTREME_KERNEL_SIZE = 3,
    parameter int DIFF_WIDTH          = DEFAULT_DIFF_WIDTH,
    localparam int K  = EXTREME_KERNEL_SIZE,
    localparam int DW = DIFF_WIDTH,
    localparam int CW = $clog2(IMAGE_COLUMN),
    localparam int RW = $clog2(IMAGE_ROW)
) (
    input  logic                 axi_clk,
    input  logic                 axi_rst,
    input  logic [K-1:0]         diff_valid,
    input  logic [K*DW-1:0]      diff_data,
    output logic [K-1:0]         extreme_valid,
    output logic [K*K*DW-1:0]    extreme_kernel [K],
    output logic [CW-1:0]        center_col,
    output logic [RW-1:0]        center_row,
    output logic                 frame_done,
    output logic                 sync_err
);
    if (EXTREME_KERNEL_SIZE != 3) begin : g_bad_kernel
        $error("extreme_window_gen supports EXTREME_KERNEL_SIZE == 3 only");
    end

    // Asserts at once, releases on the clock so every stage leaves reset together.
    logic [1:0] rst_sync;
    logic       rst;
    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) rst_sync <= 2'b11;
        else         rst_sync <= {rst_sync[0], 1'b0};
    end
    assign rst = rst_sync[1];

    logic accept, misalign;
    assign accept   = &diff_valid;
    assign misalign = (|diff_valid) && !accept;

    logic [CW-1:0]   col, col_d;
    logic [RW-1:0]   row, row_d;
    logic            bank, bank_d, acc_d;
    logic [K*DW-1:0] pix_d;

    always_ff @(posedge axi_clk or posedge rst) begin
        if (rst) begin
            col <= '0; row <= '0; bank <= 1'b0; sync_err <= 1'b0;
            col_d <= '0; row_d <= '0; bank_d <= 1'b0; acc_d <= 1'b0; pix_d <= '0;
        end else begin
            if (misalign) sync_err <= 1'b1;
            acc_d <= accept;
            if (accept) begin
                col_d  <= col;
                row_d  <= row;
                bank_d <= bank;
                pix_d  <= diff_data;
                if (col == CW'(IMAGE_COLUMN - 1)) begin
                    col  <= '0;
                    bank <= ~bank;
                    row  <= (row == RW'(IMAGE_ROW - 1)) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    logic [LB_ROWS*DW-1:0] lb_rd [K];
    for (genvar l = 0; l < K; l++) begin : g_lb
        extreme_line_buffer #(.WIDTH(DW), .DEPTH(IMAGE_COLUMN), .AW(CW)) u_lb (
            .clk     (axi_clk),
            .en      (accept),
            .wr_lane (bank ? 2'b10 : 2'b01),
            .addr    (col),
            .wdata   (diff_data[l*DW +: DW]),
            .rdata   (lb_rd[l])
        );
    end

    // new_col[l][r]: r=0 row-2, r=1 row-1, r=2 current row at the accepted column.
    logic [K-1:0][DW-1:0] new_col [K];
    always_comb begin
        for (int l = 0; l < K; l++) begin
            new_col[l][0] = bank_d ? lb_rd[l][DW +: DW] : lb_rd[l][0 +: DW];
            new_col[l][1] = bank_d ? lb_rd[l][0 +: DW]  : lb_rd[l][DW +: DW];
            new_col[l][2] = pix_d[l*DW +: DW];
        end
    end

    logic emit, last;
    assign emit = acc_d && (col_d >= CW'(2)) && (row_d >= RW'(2));
    assign last = (col_d == CW'(IMAGE_COLUMN - 1)) && (row_d == RW'(IMAGE_ROW - 1));

    // hist1/hist2 track the two older columns on every accept; the output kernel
    // only loads on an emitted window so it holds while valid is low.
    logic [K-1:0][DW-1:0] hist1 [K];
    logic [K-1:0][DW-1:0] hist2 [K];

    always_ff @(posedge axi_clk or posedge rst) begin
        if (rst) begin
            extreme_valid <= '0;
            frame_done    <= 1'b0;
            center_col    <= '0;
            center_row    <= '0;
            for (int l = 0; l < K; l++) begin
                hist1[l]          <= '0;
                hist2[l]          <= '0;
                extreme_kernel[l] <= '0;
            end
        end else begin
            extreme_valid <= {K{emit}};
            frame_done    <= emit && last;
            if (acc_d) begin
                for (int l = 0; l < K; l++) begin
                    hist2[l] <= hist1[l];
                    hist1[l] <= new_col[l];
                end
            end
            if (emit) begin
                center_col <= col_d - CW'(1);
                center_row <= row_d - RW'(1);
                for (int l = 0; l < K; l++) begin
                    for (int r = 0; r < K; r++) begin
                        extreme_kernel[l][(r*K+0)*DW +: DW] <= hist2[l][r];
                        extreme_kernel[l][(r*K+1)*DW +: DW] <= hist1[l][r];
                        extreme_kernel[l][(r*K+2)*DW +: DW] <= new_col[l][r];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_extreme_window_gen.sv
// tb/tb_extreme_window_gen.sv - scoreboard bench for extreme_window_gen
module tb_extreme_window_gen;
    localparam int COLS = 8;
    localparam int ROWS = 6;
    localparam int K    = 3;
    localparam int DW   = 14;
    localparam int KW   = K*K*DW;

    logic            clk = 1'b0;
    logic            rst;
    logic [K-1:0]    dv;
    logic [K*DW-1:0] dd;
    logic [K-1:0]    extreme_valid;
    logic [KW-1:0]   extreme_kernel [K];
    logic [2:0]      center_col;
    logic [2:0]      center_row;
    logic            frame_done;
    logic            sync_err;

    extreme_window_gen #(
        .IMAGE_COLUMN(COLS), .IMAGE_ROW(ROWS), .EXTREME_KERNEL_SIZE(K), .DIFF_WIDTH(DW)
    ) dut (
        .axi_clk        (clk),
        .axi_rst        (rst),
        .diff_valid     (dv),
        .diff_data      (dd),
        .extreme_valid  (extreme_valid),
        .extreme_kernel (extreme_kernel),
        .center_col     (center_col),
        .center_row     (center_row),
        .frame_done     (frame_done),
        .sync_err       (sync_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [3*KW-1:0] k;
        logic [2:0]      ccol;
        logic [2:0]      crow;
        logic            fd;
        int              tag;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   win_cnt = 0;
    int   fd_cnt = 0;
    int   br = 0;
    int   bc = 0;

    function automatic logic [DW-1:0] val(int off, int l, int r, int c);
        return DW'(off + 100*l + 8*r + c);
    endfunction

    task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(int off);
        exp_t e;
        dv = 3'b111;
        for (int l = 0; l < K; l++) dd[l*DW +: DW] = val(off, l, br, bc);
        if (br >= 2 && bc >= 2) begin
            for (int l = 0; l < K; l++)
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++)
                        e.k[l*KW + (r*K+c)*DW +: DW] = val(off, l, br-2+r, bc-2+c);
            e.ccol = 3'(bc - 1);
            e.crow = 3'(br - 1);
            e.fd   = (br == ROWS-1) && (bc == COLS-1);
            e.tag  = cyc + 2;
            q.push_back(e);
        end
        bc++;
        if (bc == COLS) begin
            bc = 0;
            br = (br == ROWS-1) ? 0 : br + 1;
        end
        @(negedge clk);
    endtask

    task automatic idle(int n);
        dv = '0;
        dd = K*DW'($urandom);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(int off, bit gaps);
        for (int i = 0; i < COLS*ROWS; i++) begin
            while (gaps && $urandom_range(0, 2) == 0) idle(1);
            send(off);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (frame_done && extreme_valid !== 3'b111) chk("frame_done_without_valid", 1, 0);
        if (extreme_valid !== 3'b000) begin
            win_cnt++;
            if (frame_done) fd_cnt++;
            chk("valid_bits", extreme_valid, 3'b111);
            if (q.size() == 0) begin
                chk("unexpected_window", 1, 0);
            end else begin
                e = q.pop_front();
                chk("kernel", {extreme_kernel[2], extreme_kernel[1], extreme_kernel[0]}, e.k);
                chk("center_col", center_col, e.ccol);
                chk("center_row", center_row, e.crow);
                chk("frame_done", frame_done, e.fd);
                chk("latency", cyc, e.tag);
            end
        end
    end

    task automatic check_zero(string tag);
        chk({tag, "_valid"}, extreme_valid, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_sync_err"}, sync_err, 0);
        chk({tag, "_center"}, {center_row, center_col}, 0);
        chk({tag, "_kernel"}, {extreme_kernel[2], extreme_kernel[1], extreme_kernel[0]}, 0);
    endtask

    initial begin
        rst = 1'b1;
        dv  = '0;
        dd  = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        win_cnt = 0; fd_cnt = 0;
        frame(0, 1'b0);
        idle(4);
        chk("gapless_windows", win_cnt, 24);
        chk("gapless_frame_done", fd_cnt, 1);
        chk("gapless_sync_err", sync_err, 0);

        win_cnt = 0; fd_cnt = 0;
        frame(1000, 1'b1);
        idle(4);
        chk("bubble_windows", win_cnt, 24);
        chk("bubble_frame_done", fd_cnt, 1);

        win_cnt = 0; fd_cnt = 0;
        for (int i = 0; i < COLS*ROWS; i++) begin
            if (i == 19) begin
                dv = 3'b011;
                dd = K*DW'($urandom);
                @(negedge clk);
                chk("sync_err_set", sync_err, 1);
            end
            send(-2000);
        end
        idle(4);
        chk("misalign_windows", win_cnt, 24);
        chk("misalign_frame_done", fd_cnt, 1);
        chk("sync_err_sticky", sync_err, 1);

        for (int i = 0; i < 3*COLS + 4; i++) send(300);
        #1;
        rst = 1'b1;
        dv  = '0;
        q.delete();
        br = 0; bc = 0;
        #1;
        check_zero("midframe_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        win_cnt = 0; fd_cnt = 0;
        frame(2000, 1'b0);
        idle(4);
        chk("post_reset_windows", win_cnt, 24);
        chk("post_reset_frame_done", fd_cnt, 1);

        win_cnt = 0; fd_cnt = 0;
        frame(-3000, 1'b0);
        frame(500, 1'b0);
        idle(4);
        chk("b2b_windows", win_cnt, 48);
        chk("b2b_frame_done", fd_cnt, 2);
        chk("scoreboard_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
